aurora_reset_seq_mc: RTL

Multi-channel Aurora reset sequencer with per-channel link watchdog and automatic retry. It runs in the `init_clk` domain and drives `reset_pb`/`pma_init` for `NUM_CH` independent Aurora cores. Each core follows the standard reset_pb → pma_init → release ordering. After release, each channel is supervised for `channel_up`; a channel that does not come up is re-sequenced a bounded number of times, then parked and flagged as failed.

---
 rtl/aurora_reset_seq_mc.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/aurora_reset_seq_mc.sv
// aurora_reset_seq_mc
// Multi-channel Aurora reset sequencer running in the init_clk domain.
// Each channel walks reset_pb -> pma_init -> release, then supervises
// channel_up. Optional watchdog (timeout, link-loss retry, FAIL parking) is
// compiled in with `define AURORA_RESET_SEQ_WATCHDOG_EN.
//
// ch_reset_req is a plain one-cycle synchronous pulse (no handshake): a high
// level on a rising edge of init_clk restarts that channel and clears its
// retry count; holding it high keeps the channel in IDLE.
// dbg_state exposes every channel FSM state, 3 bits per channel.

module aurora_reset_seq_mc #(
    parameter int NUM_CH         = 1,
    parameter int RSTPB_CYCLES   = 100,
    parameter int PMAINIT_CYCLES = 100000000,
    parameter int LINKUP_TIMEOUT = 100000000,
    parameter int MAX_RETRY      = 3,
    parameter int SYNC_STAGES    = 4
) (
    input  logic                  init_clk,
    input  logic                  init_rst_n,
    input  logic                  init_clk_locked,
    input  logic [NUM_CH-1:0]     sys_reset_in,
    input  logic [NUM_CH-1:0]     channel_up,
    input  logic [NUM_CH-1:0]     ch_reset_req,
    output logic [NUM_CH-1:0]     reset_pb_out,
    output logic [NUM_CH-1:0]     pma_init_out,
    output logic [NUM_CH-1:0]     done,
    output logic [NUM_CH-1:0]     link_ok,
    output logic [NUM_CH-1:0]     fail,
    output logic [4*NUM_CH-1:0]   retry_cnt,
    output logic [3*NUM_CH-1:0]   dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_RSTPB       = 3'd1,
        ST_PMAINIT     = 3'd2,
        ST_WAIT_SYSRST = 3'd3,
        ST_RELEASED    = 3'd4,
        ST_LINK_UP     = 3'd5,
        ST_RETRY       = 3'd6,
        ST_FAIL        = 3'd7
    } state_t;

    // Lock synchroniser, shared by all channels; deliberately not reset.
    logic [SYNC_STAGES-1:0] r_lock_sync;
    logic                   w_lock;

    // Shift the async MMCM lock through the synchroniser chain.
    always_ff @(posedge init_clk) begin
        r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], init_clk_locked};
    end

    assign w_lock = r_lock_sync[SYNC_STAGES-1];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_t                 r_state;
        state_t                 w_state_nxt;
        logic [31:0]            r_cnt;
        logic [31:0]            w_cnt_nxt;
        logic [SYNC_STAGES-1:0] r_sys_sync;
        logic [SYNC_STAGES-1:0] r_up_sync;
        logic                   w_sys;
        logic                   w_up;
        logic                   r_pb;
        logic                   r_pma;
        logic                   r_done;
        logic                   r_link;
`ifdef AURORA_RESET_SEQ_WATCHDOG_EN
        logic [3:0]             r_retry;
        logic [3:0]             w_retry_nxt;
        logic                   r_fail;
`endif

        // Per-channel synchronisers for sys_reset_out and channel_up; not reset.
        always_ff @(posedge init_clk) begin
            r_sys_sync <= {r_sys_sync[SYNC_STAGES-2:0], sys_reset_in[gi]};
            r_up_sync  <= {r_up_sync[SYNC_STAGES-2:0], channel_up[gi]};
        end

        assign w_sys = r_sys_sync[SYNC_STAGES-1];
        assign w_up  = r_up_sync[SYNC_STAGES-1];

        // Next-state, counter and retry logic; ch_reset_req overrides all.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
`ifdef AURORA_RESET_SEQ_WATCHDOG_EN
            w_retry_nxt = r_retry;
`endif
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_RSTPB;
                    w_cnt_nxt   = 32'd0;
                end
                ST_RSTPB: begin
                    if (r_cnt == 32'(RSTPB_CYCLES - 1)) begin
                        w_state_nxt = ST_PMAINIT;
                        w_cnt_nxt   = 32'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 32'd1;
                    end
                end
                ST_PMAINIT: begin
                    if (r_cnt == 32'(PMAINIT_CYCLES - 1)) begin
                        w_state_nxt = ST_WAIT_SYSRST;
                        w_cnt_nxt   = 32'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 32'd1;
                    end
                end
                ST_WAIT_SYSRST: begin
                    if (w_sys) begin
                        w_state_nxt = ST_RELEASED;
                        w_cnt_nxt   = 32'd0;
                    end
                end
                ST_RELEASED: begin
                    if (w_up) begin
                        w_state_nxt = ST_LINK_UP;
                    end
`ifdef AURORA_RESET_SEQ_WATCHDOG_EN
                    else if (r_cnt == 32'(LINKUP_TIMEOUT - 1)) begin
                        w_state_nxt = ST_RETRY;
                    end else begin
                        w_cnt_nxt = r_cnt + 32'd1;
                    end
`endif
                end
                ST_LINK_UP: begin
`ifdef AURORA_RESET_SEQ_WATCHDOG_EN
                    if (!w_up) begin
                        w_state_nxt = ST_RETRY;
                    end
`endif
                end
                ST_RETRY: begin
`ifdef AURORA_RESET_SEQ_WATCHDOG_EN
                    // Retry count saturates at MAX_RETRY; the next retry parks.
                    if (r_retry < 4'(MAX_RETRY)) begin
                        w_retry_nxt = r_retry + 4'd1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_FAIL;
                    end
`else
                    w_state_nxt = ST_IDLE;
`endif
                end
                ST_FAIL: begin
`ifndef AURORA_RESET_SEQ_WATCHDOG_EN
                    w_state_nxt = ST_IDLE;
`endif
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            if (ch_reset_req[gi]) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 32'd0;
`ifdef AURORA_RESET_SEQ_WATCHDOG_EN
                w_retry_nxt = 4'd0;
`endif
            end
        end

        // State register; reset or loss of lock forces a global restart.
        always_ff @(posedge init_clk) begin
            if (!init_rst_n || !w_lock) begin
                r_state <= ST_IDLE;
                r_cnt   <= 32'd0;
`ifdef AURORA_RESET_SEQ_WATCHDOG_EN
                r_retry <= 4'd0;
`endif
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
`ifdef AURORA_RESET_SEQ_WATCHDOG_EN
                r_retry <= w_retry_nxt;
`endif
            end
        end

        // Registered output decode of the current state (one cycle lag).
        always_ff @(posedge init_clk) begin
            if (!init_rst_n) begin
                r_pb   <= 1'b1;
                r_pma  <= 1'b0;
                r_done <= 1'b0;
                r_link <= 1'b0;
`ifdef AURORA_RESET_SEQ_WATCHDOG_EN
                r_fail <= 1'b0;
`endif
            end else begin
                r_pb   <= !((r_state == ST_RELEASED) || (r_state == ST_LINK_UP));
                r_pma  <= (r_state == ST_PMAINIT);
                r_done <= (r_state == ST_RELEASED) || (r_state == ST_LINK_UP);
                r_link <= (r_state == ST_LINK_UP);
`ifdef AURORA_RESET_SEQ_WATCHDOG_EN
                r_fail <= (r_state == ST_FAIL);
`endif
            end
        end

        assign reset_pb_out[gi]     = r_pb;
        assign pma_init_out[gi]     = r_pma;
        assign done[gi]             = r_done;
        assign link_ok[gi]          = r_link;
        assign dbg_state[3*gi +: 3] = r_state;
`ifdef AURORA_RESET_SEQ_WATCHDOG_EN
        assign fail[gi]             = r_fail;
        assign retry_cnt[4*gi +: 4] = r_retry;
`else
        assign fail[gi]             = 1'b0;
        assign retry_cnt[4*gi +: 4] = 4'd0;
`endif
    end

endmodule
